// File: rtl/ti_ctrl_pkg.sv
// ti_ctrl_pkg: shared state encoding and constants for the task-interruption clock controller
package ti_ctrl_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, HALT, STEP} state_t;
  localparam int STEP_W = 4;
  localparam logic [63:0] BP_DISABLED = '1;
endpackage

// File: rtl/ti_axis_boundary_tracker.sv
// ti_axis_boundary_tracker: tracks whether an AXIS link is mid-packet and flags safe frame boundaries
module ti_axis_boundary_tracker (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tvalid,
  input  logic tready,
  input  logic tlast,
  output logic boundary
);
  logic in_pkt;
  logic hs;
  assign hs = tvalid & tready;
  assign boundary = ~in_pkt & ~hs;
  // a non-last beat opens a packet, the last beat closes it; clear abandons the packet
  always_ff @(posedge clk)
    in_pkt <= (rst | clear) ? 1'b0 : hs ? ~tlast : in_pkt;
endmodule

// File: rtl/ti_clock_controller.sv
// ti_clock_controller: user-clock enable arbiter (run/halt/step/breakpoint); TI_DRAIN_TIMEOUT_EN adds a forced-grant drain timeout
module ti_clock_controller
  import ti_ctrl_pkg::*;
#(
  parameter int STEP_CYCLES = 2,
`ifdef TI_DRAIN_TIMEOUT_EN
  parameter int DRAIN_TIMEOUT = 1024,
`endif
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ti_req,
  input  logic             pr_done,
  input  logic             clk_en,
  input  logic             clk_step,
  input  logic [CNT_W-1:0] breakpoint,
  input  logic             mon_tvalid,
  input  logic             mon_tready,
  input  logic             mon_tlast,
  output logic             user_ce,
  output logic             ti_gnt,
  output logic             bp_hit,
  output logic             drain_forced,
  output logic [CNT_W-1:0] cycle_cnt
);
  state_t state, state_n;
  logic [STEP_W-1:0] step_left, step_n;
  logic step_q, step_rise, boundary, bp_now, resume, timeout, trk_clear;
  logic ce_n, gnt_n, bp_n;
  assign step_rise = clk_step & ~step_q;
  assign resume = (state == HALT) & pr_done & clk_en;
  assign bp_now = user_ce & (breakpoint != BP_DISABLED[CNT_W-1:0]) & (cycle_cnt + CNT_W'(1) == breakpoint);
  ti_axis_boundary_tracker u_rx_trk (
    .clk(clk),
    .rst(rst),
    .clear(trk_clear),
    .tvalid(mon_tvalid),
    .tready(mon_tready),
    .tlast(mon_tlast),
    .boundary(boundary)
  );
`ifdef TI_DRAIN_TIMEOUT_EN
  logic [15:0] drain_cnt;
  logic force_gnt;
  assign timeout = (state == DRAIN) & (drain_cnt == 16'(DRAIN_TIMEOUT - 1));
  assign force_gnt = (state == DRAIN) & ~bp_now & ~boundary & timeout;
  assign trk_clear = force_gnt;
  // cycles spent waiting for a boundary; restarts whenever DRAIN is left
  always_ff @(posedge clk)
    drain_cnt <= (rst || state != DRAIN) ? '0 : drain_cnt + 16'd1;
  // sticky flag for a grant that had to give up on the packet boundary
  always_ff @(posedge clk)
    drain_forced <= rst ? 1'b0 : force_gnt ? 1'b1 : resume ? 1'b0 : drain_forced;
`else
  assign timeout = 1'b0;
  assign trk_clear = 1'b0;
  assign drain_forced = 1'b0;
`endif
  // next state; a new halt asserts the grant on the same edge the enable drops
  always_comb begin
    state_n = state;
    step_n = step_left;
    gnt_n = ti_gnt;
    bp_n = bp_hit;
    unique case (state)
      RUN: begin
        state_n = bp_now ? HALT : ti_req ? DRAIN : RUN;
        gnt_n = ti_gnt | bp_now;
        bp_n = bp_hit | bp_now;
      end
      DRAIN: begin
        state_n = (bp_now | boundary | timeout) ? HALT : DRAIN;
        gnt_n = ti_gnt | bp_now | boundary | timeout;
        bp_n = bp_hit | bp_now;
      end
      HALT: begin
        state_n = resume ? RUN : (~pr_done & step_rise) ? STEP : HALT;
        step_n = (~pr_done & step_rise) ? STEP_W'(STEP_CYCLES) : step_left;
        gnt_n = ti_gnt & ~pr_done;
        bp_n = bp_hit & ~resume;
      end
      STEP: begin
        state_n = (step_left <= STEP_W'(1)) ? HALT : STEP;
        step_n = (step_left <= STEP_W'(1)) ? '0 : step_left - STEP_W'(1);
      end
      default: state_n = RUN;
    endcase
    ce_n = (state_n == RUN) | (state_n == DRAIN) | ((state_n == STEP) & (step_n != '0));
  end
  // state, registered enable/flags and the enabled-cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      step_left <= '0;
      step_q <= 1'b0;
      user_ce <= 1'b0;
      ti_gnt <= 1'b0;
      bp_hit <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      state <= state_n;
      step_left <= step_n;
      step_q <= clk_step;
      user_ce <= ce_n;
      ti_gnt <= gnt_n;
      bp_hit <= bp_n;
      cycle_cnt <= cycle_cnt + CNT_W'(user_ce);
    end
  end
endmodule

// File: tb/tb_ti_clock_controller.sv
// tb_ti_clock_controller: vector-table and scoreboard bench for ti_clock_controller
module tb_ti_clock_controller;
  localparam logic [31:0] D = 32'hFFFF_FFFF;
  logic clk = 1'b0;
  logic rst, ti_req, pr_done, clk_en, clk_step, mon_tvalid, mon_tready, mon_tlast;
  logic [31:0] breakpoint;
  logic user_ce, ti_gnt, bp_hit, drain_forced;
  logic [31:0] cycle_cnt;
  typedef struct {
    logic r, tq, pd, en, st, tv, tr, tl;
    logic [31:0] bp;
    int n;
    logic ce, gnt, bph, f;
    logic [31:0] cnt;
  } vec_t;
  typedef struct {
    logic ce, gnt, bph, f;
    logic [31:0] cnt;
  } exp_t;
  vec_t vecs[$];
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  ti_clock_controller dut (
    .clk(clk),
    .rst(rst),
    .ti_req(ti_req),
    .pr_done(pr_done),
    .clk_en(clk_en),
    .clk_step(clk_step),
    .breakpoint(breakpoint),
    .mon_tvalid(mon_tvalid),
    .mon_tready(mon_tready),
    .mon_tlast(mon_tlast),
    .user_ce(user_ce),
    .ti_gnt(ti_gnt),
    .bp_hit(bp_hit),
    .drain_forced(drain_forced),
    .cycle_cnt(cycle_cnt)
  );
  function automatic vec_t v(input logic r, tq, pd, en, st, tv, tr, tl, input logic [31:0] bp,
                             input int n, input logic ce, gnt, bph, f, input logic [31:0] cnt);
    vec_t x;
    x.r = r; x.tq = tq; x.pd = pd; x.en = en; x.st = st; x.tv = tv; x.tr = tr; x.tl = tl;
    x.bp = bp; x.n = n; x.ce = ce; x.gnt = gnt; x.bph = bph; x.f = f; x.cnt = cnt;
    return x;
  endfunction
  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0d want %0d", nm, idx, act, exp);
    end
  endtask
  initial begin
    exp_t e;
    //            r  tq pd en st tv tr tl bp   n      ce gnt bp f  cnt
    vecs.push_back(v(1, 0, 0, 1, 0, 0, 0, 0, D,   5,     0, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, D,   1,     1, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, D,   5,     1, 0, 0, 0, 5));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 100, 94,    1, 0, 0, 0, 99));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 100, 1,     0, 1, 1, 0, 100));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 100, 10,    0, 1, 1, 0, 100));
    vecs.push_back(v(0, 0, 1, 1, 0, 0, 0, 0, 100, 1,     1, 0, 0, 0, 100));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, D,   3,     1, 0, 0, 0, 103));
    vecs.push_back(v(0, 1, 0, 1, 0, 0, 0, 0, D,   1,     1, 0, 0, 0, 104));
    vecs.push_back(v(0, 1, 0, 1, 0, 0, 0, 0, D,   1,     0, 1, 0, 0, 105));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, D,   3,     0, 1, 0, 0, 105));
    vecs.push_back(v(0, 0, 0, 1, 1, 0, 0, 0, D,   1,     1, 1, 0, 0, 105));
    vecs.push_back(v(0, 0, 0, 1, 1, 0, 0, 0, D,   1,     1, 1, 0, 0, 106));
    vecs.push_back(v(0, 0, 0, 1, 1, 0, 0, 0, D,   1,     0, 1, 0, 0, 107));
    vecs.push_back(v(0, 0, 0, 1, 1, 0, 0, 0, D,   3,     0, 1, 0, 0, 107));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, D,   1,     0, 1, 0, 0, 107));
    vecs.push_back(v(0, 0, 0, 1, 1, 0, 0, 0, D,   2,     1, 1, 0, 0, 108));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, D,   2,     0, 1, 0, 0, 109));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, D,   1,     0, 0, 0, 0, 109));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, D,   2,     0, 0, 0, 0, 109));
    vecs.push_back(v(0, 0, 1, 1, 1, 0, 0, 0, D,   1,     1, 0, 0, 0, 109));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, D,   2,     1, 0, 0, 0, 111));
    vecs.push_back(v(0, 1, 0, 1, 0, 0, 0, 0, 112, 1,     0, 1, 1, 0, 112));
    vecs.push_back(v(0, 0, 1, 1, 0, 0, 0, 0, 112, 1,     1, 0, 0, 0, 112));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, D,   1,     1, 0, 0, 0, 113));
    vecs.push_back(v(0, 0, 0, 1, 0, 1, 1, 0, D,   3,     1, 0, 0, 0, 116));
    vecs.push_back(v(0, 1, 0, 1, 0, 1, 1, 0, D,   1,     1, 0, 0, 0, 117));
    vecs.push_back(v(0, 0, 0, 1, 0, 1, 1, 0, D,   3,     1, 0, 0, 0, 120));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 1, 0, D,   2,     1, 0, 0, 0, 122));
    vecs.push_back(v(0, 0, 0, 1, 0, 1, 1, 1, D,   1,     1, 0, 0, 0, 123));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, D,   1,     0, 1, 0, 0, 124));
    vecs.push_back(v(0, 0, 1, 1, 0, 0, 0, 0, D,   1,     1, 0, 0, 0, 124));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, D,   2,     1, 0, 0, 0, 126));
    vecs.push_back(v(0, 1, 0, 1, 0, 0, 0, 0, D,   2,     0, 1, 0, 0, 128));
    vecs.push_back(v(0, 0, 0, 1, 1, 0, 0, 0, D,   1,     1, 1, 0, 0, 128));
    vecs.push_back(v(1, 0, 0, 1, 0, 0, 0, 0, D,   1,     0, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, D,   2,     1, 0, 0, 0, 1));
`ifdef TI_DRAIN_TIMEOUT_EN
    vecs.push_back(v(0, 0, 0, 1, 0, 1, 1, 0, D,   1,     1, 0, 0, 0, 2));
    vecs.push_back(v(0, 1, 0, 1, 0, 1, 0, 0, D,   1,     1, 0, 0, 0, 3));
    vecs.push_back(v(0, 1, 0, 1, 0, 1, 0, 0, D,   1023,  1, 0, 0, 0, 1026));
    vecs.push_back(v(0, 1, 0, 1, 0, 1, 0, 0, D,   1,     0, 1, 0, 1, 1027));
    vecs.push_back(v(0, 0, 1, 1, 0, 0, 0, 0, D,   1,     1, 0, 0, 0, 1027));
`endif
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].r; ti_req = vecs[i].tq; pr_done = vecs[i].pd; clk_en = vecs[i].en;
      clk_step = vecs[i].st; mon_tvalid = vecs[i].tv; mon_tready = vecs[i].tr;
      mon_tlast = vecs[i].tl; breakpoint = vecs[i].bp;
      sb.push_back('{vecs[i].ce, vecs[i].gnt, vecs[i].bph, vecs[i].f, vecs[i].cnt});
      repeat (vecs[i].n) @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("user_ce", i, 32'(user_ce), 32'(e.ce));
      chk("ti_gnt", i, 32'(ti_gnt), 32'(e.gnt));
      chk("bp_hit", i, 32'(bp_hit), 32'(e.bph));
      chk("drain_forced", i, 32'(drain_forced), 32'(e.f));
      chk("cycle_cnt", i, cycle_cnt, e.cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
